// File: rtl/dma_reader.sv
// AXI3 burst read master: fetches NUM_BYTES from BASE_ADDR in 16-beat INCR bursts into a FWFT FIFO.
// Build option: define DMA_READER_ERR_ABORT_EN to end the transfer after a burst that carried an error response.
module dma_reader #(
   parameter logic [31:0] BASE_ADDR  = 32'h1F00_0000,
   parameter logic [31:0] NUM_BYTES  = 32'h000C_3500,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic        aclk,
   input  logic        rst_ni,
   output logic [31:0] m_axi_araddr,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [3:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   input  logic [63:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic        enable_i,
   output logic [63:0] data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        finished_o,
   output logic        error_o
);

   // state  | meaning
   // IDLE   | waiting for the first enable rising edge after reset
   // ADDR   | presenting a burst address once the FIFO can hold 16 beats
   // DATA   | accepting the beats of the single outstanding burst
   // DONE   | region fetched (or aborted); finished_o once the FIFO drains
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

   localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] AR_THRESH = CNT_W'(FIFO_DEPTH - 16);
   localparam logic [32:0]      END_ADDR  = {1'b0, BASE_ADDR} + {1'b0, NUM_BYTES};
   localparam logic [28:0]      NUM_BEATS = NUM_BYTES[31:3];

   state_e             state_q, state_d;
   logic [2:0]         en_sync_q, en_sync_d;
   logic [31:0]        addr_q, addr_d;
   logic [28:0]        beats_left_q, beats_left_d;
   logic [3:0]         beat_cnt_q, beat_cnt_d;
   logic               arvalid_q, arvalid_d;
   logic               rready_q, rready_d;
   logic               finished_q, finished_d;
   logic               error_q, error_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [63:0]        mem_q [FIFO_DEPTH];

   logic               start;
   logic               push;
   logic               pop;
   logic               beat_err;
   logic               last_beat;
   logic               abort;
   logic               clear;
   logic [32:0]        next_addr;

   assign start     = en_sync_q[1] & ~en_sync_q[2];
   assign push      = m_axi_rvalid & rready_q;
   assign valid_o   = (cnt_q != '0);
   assign pop       = valid_o & ready_i;
   assign beat_err  = push & (m_axi_rresp != 2'b00);
   assign last_beat = push & (m_axi_rlast | (beat_cnt_q == 4'd15));
   assign next_addr = {1'b0, addr_q} + 33'd128;

`ifdef DMA_READER_ERR_ABORT_EN
   assign abort = error_q | beat_err;
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      en_sync_d    = {en_sync_q[1:0], enable_i};
      state_d      = state_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      beat_cnt_d   = beat_cnt_q;
      error_d      = error_q;
      clear        = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_ADDR;
               addr_d       = BASE_ADDR;
               beats_left_d = NUM_BEATS;
               error_d      = 1'b0;
               clear        = 1'b1;
            end
         end
         S_ADDR: begin
            if (arvalid_q && m_axi_arready) begin
               state_d    = S_DATA;
               beat_cnt_d = 4'd0;
            end
         end
         S_DATA: begin
            if (push) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               if (beats_left_q != '0) begin
                  beats_left_d = beats_left_q - 29'd1;
               end
               if (last_beat) begin
                  addr_d = next_addr[31:0];
                  if ((next_addr >= END_ADDR) || (beats_left_d == '0) || abort) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ADDR;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (beat_err) begin
         error_d = 1'b1;
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      // Only request a burst while the whole 16 beats are guaranteed to fit.
      arvalid_d  = (state_d == S_ADDR) && (cnt_d <= AR_THRESH);
      rready_d   = (state_d == S_DATA);
      finished_d = (state_d == S_DONE) && (cnt_d == '0);
   end

   always_ff @(posedge aclk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         en_sync_q    <= '0;
         addr_q       <= BASE_ADDR;
         beats_left_q <= '0;
         beat_cnt_q   <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         finished_q   <= 1'b0;
         error_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         en_sync_q    <= en_sync_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         beat_cnt_q   <= beat_cnt_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         finished_q   <= finished_d;
         error_q      <= error_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= m_axi_rdata;
      end
   end

   assign m_axi_araddr  = addr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_arlen   = 4'd15;
   assign m_axi_arsize  = 3'd3;
   assign m_axi_arburst = 2'b01;
   assign m_axi_rready  = rready_q;
   assign data_o        = valid_o ? mem_q[rd_ptr_q] : 64'd0;
   assign finished_o    = finished_q;
   assign error_o       = error_q;

endmodule
